fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage RV32I pipeline. It holds the program counter and issues the fetch address to instruction memory. A direct-mapped branch target buffer (BTB) with 2-bit saturating counters selects the next PC. The stage drives the PC and predicted-taken flag that the F/D pipeline register captures as its F-side inputs (PCF, TakeJBF). The execute stage trains the predictor and redirects the PC on a misprediction.

---
 rtl/fetch_stage.sv | 87 ++++++++
 tb/tb_fetch_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register with a direct-mapped BTB and
// 2-bit saturating counters selecting the next fetch address.
module fetch_stage #(
    parameter int unsigned BTB_ENTRIES = 16,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iStallF,
    input  logic        iRecoverE,
    input  logic [31:0] iRecoverPCE,
    input  logic        iBranchE,
    input  logic        iTakenE,
    input  logic [31:0] iPCE,
    input  logic [31:0] iTargetE,
    output logic [31:0] oPCF,
    output logic        oTakeJBF,
    output logic [31:0] oNextPCF
);

    localparam int unsigned IW = $clog2(BTB_ENTRIES);
    localparam int unsigned TW = 30 - IW;

    logic [BTB_ENTRIES-1:0] valid;
    logic [TW-1:0]          tag_q [BTB_ENTRIES];
    logic [31:0]            tgt_q [BTB_ENTRIES];
    logic [1:0]             ctr_q [BTB_ENTRIES];

    logic [31:0]   pc;
    logic [IW-1:0] idx_f;
    logic [IW-1:0] idx_e;
    logic [TW-1:0] tag_f;
    logic [TW-1:0] tag_e;
    logic          hit_f;
    logic          hit_e;
    logic [1:0]    ctr_e;

    assign idx_f = pc[IW+1:2];
    assign tag_f = pc[31:IW+2];
    assign idx_e = iPCE[IW+1:2];
    assign tag_e = iPCE[31:IW+2];

    assign hit_f = valid[idx_f] && (tag_q[idx_f] == tag_f);
    assign hit_e = valid[idx_e] && (tag_q[idx_e] == tag_e);
    assign ctr_e = ctr_q[idx_e];

    assign oPCF     = pc;
    assign oTakeJBF = hit_f && ctr_q[idx_f][1];
    assign oNextPCF = oTakeJBF ? tgt_q[idx_f] : pc + 32'd4;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            pc    <= RESET_PC;
            valid <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else begin
            if (iRecoverE) begin
                pc <= iRecoverPCE;
            end else if (!iStallF) begin
                pc <= oNextPCF;
            end
            if (iBranchE) begin
                if (iTakenE) begin
                    valid[idx_e] <= 1'b1;
                    if (!hit_e) begin
                        ctr_q[idx_e] <= 2'b10;
                    end else if (ctr_e != 2'b11) begin
                        ctr_q[idx_e] <= ctr_e + 2'b01;
                    end
                end else if (hit_e && ctr_e != 2'b00) begin
                    ctr_q[idx_e] <= ctr_e - 2'b01;
                end
            end
        end
    end

    // Tag/target need no reset; rewriting the tag on a taken hit is harmless.
    always_ff @(posedge iClk) begin
        if (!iRst && iBranchE && iTakenE) begin
            tag_q[idx_e] <= tag_e;
            tgt_q[idx_e] <= iTargetE;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, a same-cycle
// write/read sequence, and randomized traffic against a BTB model.
module tb_fetch_stage;

    localparam int N = 16;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        rec;
    logic [31:0] rec_pc;
    logic        br;
    logic        tk;
    logic [31:0] pce;
    logic [31:0] tgt;
    logic [31:0] pcf;
    logic        take;
    logic [31:0] nxt;

    int checks = 0;
    int failures = 0;

    fetch_stage #(.BTB_ENTRIES(N), .RESET_PC(32'h0)) dut (
        .iClk(clk),
        .iRst(rst),
        .iStallF(stall),
        .iRecoverE(rec),
        .iRecoverPCE(rec_pc),
        .iBranchE(br),
        .iTakenE(tk),
        .iPCE(pce),
        .iTargetE(tgt),
        .oPCF(pcf),
        .oTakeJBF(take),
        .oNextPCF(nxt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r, s, c;
        logic [31:0] rp;
        logic        b, t;
        logic [31:0] pe, tg;
        logic [31:0] epc;
        logic        etk;
        logic [31:0] enx;
    } vec_t;

    vec_t tbl[$];

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    function automatic vec_t v(input logic r, input logic s, input logic c,
                               input logic [31:0] rp, input logic b,
                               input logic t, input logic [31:0] pe,
                               input logic [31:0] tg, input logic [31:0] epc,
                               input logic etk, input logic [31:0] enx);
        vec_t x;
        x.r = r; x.s = s; x.c = c; x.rp = rp; x.b = b; x.t = t;
        x.pe = pe; x.tg = tg; x.epc = epc; x.etk = etk; x.enx = enx;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic c,
                         input logic [31:0] rp, input logic b,
                         input logic t, input logic [31:0] pe,
                         input logic [31:0] tg);
        rst = r; stall = s; rec = c; rec_pc = rp;
        br = b; tk = t; pce = pe; tgt = tg;
    endtask

    // Reference BTB model, indexed arithmetically from the PC.
    bit          m_val [N];
    int unsigned m_tag [N];
    logic [31:0] m_tgt [N];
    int          m_ctr [N];
    logic [31:0] m_pc;

    function automatic int unsigned midx(input logic [31:0] a);
        return (a / 4) % N;
    endfunction

    function automatic int unsigned mtag(input logic [31:0] a);
        return a / (4 * N);
    endfunction

    function automatic logic mhit(input logic [31:0] a);
        return m_val[midx(a)] && m_tag[midx(a)] == mtag(a);
    endfunction

    function automatic logic mtake(input logic [31:0] a);
        return mhit(a) && m_ctr[midx(a)] >= 2;
    endfunction

    function automatic logic [31:0] mnext(input logic [31:0] a);
        return mtake(a) ? m_tgt[midx(a)] : a + 32'd4;
    endfunction

    initial begin
        drive(L, L, L, 0, L, L, 0, 0);

        tbl.push_back(v(H, L, H, 'h200, H, H, 'h0, 'h80, 'h0, L, 'h4));
        tbl.push_back(v(L, L, L, 0, L, L, 0, 0, 'h4, L, 'h8));
        tbl.push_back(v(L, L, L, 0, L, L, 0, 0, 'h8, L, 'hC));
        tbl.push_back(v(L, L, L, 0, L, L, 0, 0, 'hC, L, 'h10));
        tbl.push_back(v(L, L, H, 'h8, L, L, 0, 0, 'h8, L, 'hC));
        tbl.push_back(v(L, H, L, 0, L, L, 0, 0, 'h8, L, 'hC));
        tbl.push_back(v(L, H, L, 0, L, L, 0, 0, 'h8, L, 'hC));
        tbl.push_back(v(L, H, L, 0, L, L, 0, 0, 'h8, L, 'hC));
        tbl.push_back(v(L, H, H, 'h100, L, L, 0, 0, 'h100, L, 'h104));
        tbl.push_back(v(L, L, H, 'h10, H, H, 'h10, 'h40, 'h10, H, 'h40));
        tbl.push_back(v(L, L, L, 0, L, L, 0, 0, 'h40, L, 'h44));
        tbl.push_back(v(L, L, H, 'h10, H, L, 'h10, 0, 'h10, L, 'h14));
        tbl.push_back(v(L, H, L, 0, H, H, 'h10, 'h40, 'h10, H, 'h40));
        tbl.push_back(v(L, H, L, 0, H, H, 'h10, 'h40, 'h10, H, 'h40));
        tbl.push_back(v(L, H, L, 0, H, H, 'h10, 'h40, 'h10, H, 'h40));
        tbl.push_back(v(L, H, L, 0, H, L, 'h10, 0, 'h10, H, 'h40));
        tbl.push_back(v(L, L, H, 'h50, L, L, 0, 0, 'h50, L, 'h54));
        tbl.push_back(v(L, H, L, 0, H, L, 'h50, 0, 'h50, L, 'h54));
        tbl.push_back(v(L, L, H, 'h10, L, L, 0, 0, 'h10, H, 'h40));
        tbl.push_back(v(L, L, H, 'h20, L, L, 0, 0, 'h20, L, 'h24));
        tbl.push_back(v(L, H, L, 0, H, H, 'h20, 'h80, 'h20, H, 'h80));
        tbl.push_back(v(L, L, L, 0, L, L, 0, 0, 'h80, L, 'h84));
        tbl.push_back(v(L, L, H, 'hFFFF_FFFC, L, L, 0, 0, 'hFFFF_FFFC, L, 'h0));
        tbl.push_back(v(L, L, L, 0, L, L, 0, 0, 'h0, L, 'h4));
        tbl.push_back(v(H, H, H, 'h20, H, H, 'h0, 'h80, 'h0, L, 'h4));
        tbl.push_back(v(L, L, H, 'h10, L, L, 0, 0, 'h10, L, 'h14));

        @(negedge clk);
        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].s, tbl[i].c, tbl[i].rp,
                  tbl[i].b, tbl[i].t, tbl[i].pe, tbl[i].tg);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_pc", i), pcf, tbl[i].epc);
            chk($sformatf("vec%0d_take", i), {31'b0, take}, {31'b0, tbl[i].etk});
            chk($sformatf("vec%0d_next", i), nxt, tbl[i].enx);
        end

        // Same-cycle write and lookup of an empty entry: no bypass.
        drive(H, L, L, 0, L, L, 0, 0);
        @(posedge clk); #1;
        drive(L, L, H, 'h30, L, L, 0, 0);
        @(posedge clk); #1;
        drive(L, H, L, 0, H, H, 'h30, 'h90);
        #1;
        chk("same_cycle_pc", pcf, 'h30);
        chk("same_cycle_take", {31'b0, take}, 32'd0);
        chk("same_cycle_next", nxt, 'h34);
        @(posedge clk); #1;
        drive(L, L, L, 0, L, L, 0, 0);
        chk("after_write_take", {31'b0, take}, 32'd1);
        chk("after_write_next", nxt, 'h90);
        @(posedge clk); #1;
        chk("after_write_pc", pcf, 'h90);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic        r, s, c, b, t;
            logic [31:0] rp, pe, tg, exp_next;
            int unsigned ix;
            r  = (n == 0) || ($urandom_range(0, 99) == 0);
            s  = $urandom_range(0, 3) == 0;
            c  = $urandom_range(0, 6) == 0;
            b  = $urandom_range(0, 9) < 4;
            t  = $urandom_range(0, 2) != 0;
            rp = 32'($urandom_range(0, 127)) << 2;
            pe = 32'($urandom_range(0, 127)) << 2;
            tg = 32'($urandom_range(0, 127)) << 2;
            drive(r, s, c, rp, b, t, pe, tg);
            exp_next = mnext(m_pc);
            if (r) begin
                m_pc = 32'h0;
                for (int k = 0; k < N; k++) begin
                    m_val[k] = 1'b0;
                    m_ctr[k] = 1;
                end
            end else begin
                if (c) m_pc = rp;
                else if (!s) m_pc = exp_next;
                ix = midx(pe);
                if (b && t && mhit(pe)) begin
                    m_ctr[ix] = (m_ctr[ix] < 3) ? m_ctr[ix] + 1 : 3;
                    m_tgt[ix] = tg;
                end else if (b && t) begin
                    m_val[ix] = 1'b1;
                    m_tag[ix] = mtag(pe);
                    m_tgt[ix] = tg;
                    m_ctr[ix] = 2;
                end else if (b && mhit(pe)) begin
                    m_ctr[ix] = (m_ctr[ix] > 0) ? m_ctr[ix] - 1 : 0;
                end
            end
            @(posedge clk); #1;
            chk("rand_pc", pcf, m_pc);
            chk("rand_take", {31'b0, take}, {31'b0, mtake(m_pc)});
            chk("rand_next", nxt, mnext(m_pc));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
